// File: rtl/cms_trace_engine_if.sv
// AXI-Stream bundle carrying trace packets from cms_trace_engine to the DMA.
interface cms_trace_engine_if #(
    parameter int DATA_W = 128
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cms_trace_engine.sv
// Trace capture engine: trigger FSM, range filters, timestamping and packet FIFO drained over AXI-Stream.
// Optional overflow markers are enabled by defining CMS_OVERFLOW_MARKER_EN.
module cms_trace_engine #(
    parameter int XLEN            = 64,
    parameter int INSTR_W         = 32,
    parameter int TS_W            = 32,
    parameter int NUM_RANGES      = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int WFI_STOP_CYCLES = 255,
    parameter int CTRL_ADDR_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [XLEN-1:0]        pc,
    input  logic [INSTR_W-1:0]     instr,
    input  logic                   pc_valid,
    input  logic [CTRL_ADDR_W-1:0] ctrl_addr,
    input  logic [XLEN-1:0]        ctrl_wdata,
    input  logic                   ctrl_we,
    input  logic [15:0]            tlast_interval,
    cms_trace_engine_if.master     M_AXIS,
    output logic [1:0]             state,
    output logic [15:0]            drop_count
);
    localparam int DATA_W = INSTR_W + TS_W + XLEN;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WFI_W  = $clog2(WFI_STOP_CYCLES + 1);
    localparam logic [INSTR_W-1:0] WFI_INSTR = INSTR_W'(32'h1050_0073);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRACING = 2'd2, DONE = 2'd3} state_t;

    state_t state_q, state_d;
    logic start_en_q, start_en_d, end_en_q, end_en_d;
    logic [NUM_RANGES-1:0] range_en_q, range_en_d;
    logic [XLEN-1:0] start_addr_q, start_addr_d, end_addr_q, end_addr_d;
    logic [NUM_RANGES-1:0][XLEN-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WFI_W-1:0] wfi_cnt_q, wfi_cnt_d;
    logic [TS_W-1:0] delta_q, delta_d;
    logic cap_valid_q, cap_valid_d, cap_end_q, cap_end_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic [15:0] tl_cnt_q, tl_cnt_d, drop_q, drop_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0] count_q, count_d;
    logic [DATA_W:0] mem_q [FIFO_DEPTH];

    logic [NUM_RANGES-1:0] in_range;
    logic filter_pass, start_hit, end_hit, wfi_valid, wfi_last, enter, capture;
    logic pop, space, push, push_cap, drop, marker_push, tl_hit, cap_last;
    logic [DATA_W:0] push_word, head;

    always_comb begin
        start_en_d   = start_en_q;
        end_en_d     = end_en_q;
        range_en_d   = range_en_q;
        start_addr_d = start_addr_q;
        end_addr_d   = end_addr_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        if (ctrl_we) begin
            if (ctrl_addr == CTRL_ADDR_W'(0)) begin
                start_en_d = ctrl_wdata[0];
                end_en_d   = ctrl_wdata[1];
                range_en_d = ctrl_wdata[2 +: NUM_RANGES];
            end
            if (ctrl_addr == CTRL_ADDR_W'(1)) start_addr_d = ctrl_wdata;
            if (ctrl_addr == CTRL_ADDR_W'(2)) end_addr_d = ctrl_wdata;
            for (int i = 0; i < NUM_RANGES; i++) begin
                if (ctrl_addr == CTRL_ADDR_W'(3 + 2 * i)) lo_d[i] = ctrl_wdata;
                if (ctrl_addr == CTRL_ADDR_W'(4 + 2 * i)) hi_d[i] = ctrl_wdata;
            end
        end
    end

    always_comb begin
        in_range = '0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            in_range[i] = range_en_q[i] && (pc >= lo_q[i]) && (pc <= hi_q[i]);
        end
        filter_pass = (range_en_q == '0) || (|in_range);
    end

    assign start_hit = pc_valid && (pc == start_addr_q);
    assign end_hit   = pc_valid && end_en_q && (pc == end_addr_q);
    assign wfi_valid = pc_valid && (instr == WFI_INSTR);
    assign wfi_last  = wfi_valid && (wfi_cnt_q == WFI_W'(WFI_STOP_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        wfi_cnt_d = '0;
        case (state_q)
            IDLE:    state_d = start_en_q ? ARMED : TRACING;
            ARMED:   if (start_hit) state_d = TRACING;
            TRACING: begin
                wfi_cnt_d = wfi_cnt_q;
                if (pc_valid) wfi_cnt_d = wfi_valid ? wfi_cnt_q + WFI_W'(1) : '0;
                if (end_hit || wfi_last) state_d = DONE;
            end
            default: state_d = state_q;
        endcase
        if (!en) state_d = IDLE;
    end

    // The start-trigger sample is captured in the same cycle the FSM leaves ARMED, with a zero delta.
    always_comb begin
        enter       = (state_d == TRACING) && (state_q != TRACING);
        capture     = pc_valid && filter_pass &&
                      ((state_q == TRACING) || ((state_q == ARMED) && (state_d == TRACING)));
        cap_valid_d = capture;
        cap_end_d   = end_hit && (state_q == TRACING);
        cap_data_d  = {instr, (enter ? {TS_W{1'b0}} : delta_q), pc};
        if (capture || enter) delta_d = TS_W'(1);
        else if (delta_q == {TS_W{1'b1}}) delta_d = delta_q;
        else delta_d = delta_q + TS_W'(1);
    end

    assign head           = mem_q[rd_ptr_q];
    assign M_AXIS.tvalid  = (count_q != '0);
    assign M_AXIS.tdata   = M_AXIS.tvalid ? head[DATA_W-1:0] : '0;
    assign M_AXIS.tlast   = M_AXIS.tvalid && head[DATA_W];
    assign pop            = M_AXIS.tvalid && M_AXIS.tready;
    assign space          = (count_q != (PTR_W+1)'(FIFO_DEPTH)) || pop;
    assign push_cap       = cap_valid_q && space && !marker_push;
    assign drop           = cap_valid_q && !push_cap;
    assign push           = push_cap || marker_push;
    assign tl_hit         = (tlast_interval != 16'd0) && ((tl_cnt_q + 16'd1) == tlast_interval);
    assign cap_last       = cap_end_q || tl_hit;

`ifdef CMS_OVERFLOW_MARKER_EN
    logic [XLEN-1:0] tally_q, tally_d;
    assign marker_push = space && (tally_q != '0);
    assign push_word   = marker_push ? {1'b0, {INSTR_W{1'b1}}, {TS_W{1'b0}}, tally_q}
                                     : {cap_last, cap_data_q};
    always_comb begin
        tally_d = tally_q;
        if (marker_push) tally_d = XLEN'(drop);
        else if (drop) tally_d = tally_q + XLEN'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) tally_q <= '0;
        else     tally_q <= tally_d;
    end
`else
    assign marker_push = 1'b0;
    assign push_word   = {cap_last, cap_data_q};
`endif

    always_comb begin
        tl_cnt_d = tl_cnt_q;
        if (push_cap) tl_cnt_d = cap_last ? 16'd0 : tl_cnt_q + 16'd1;
        drop_d   = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            start_en_q   <= 1'b0;
            end_en_q     <= 1'b0;
            range_en_q   <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            lo_q         <= '0;
            hi_q         <= '1;
            wfi_cnt_q    <= '0;
            delta_q      <= '0;
            cap_valid_q  <= 1'b0;
            cap_end_q    <= 1'b0;
            cap_data_q   <= '0;
            tl_cnt_q     <= '0;
            drop_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            start_en_q   <= start_en_d;
            end_en_q     <= end_en_d;
            range_en_q   <= range_en_d;
            start_addr_q <= start_addr_d;
            end_addr_q   <= end_addr_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            wfi_cnt_q    <= wfi_cnt_d;
            delta_q      <= delta_d;
            cap_valid_q  <= cap_valid_d;
            cap_end_q    <= cap_end_d;
            cap_data_q   <= cap_data_d;
            tl_cnt_q     <= tl_cnt_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign state      = state_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_cms_trace_engine.sv
// Self-checking bench for cms_trace_engine: scoreboard of expected AXIS beats plus directed state/counter checks.
module tb_cms_trace_engine;
    localparam logic [31:0] WFI = 32'h1050_0073;

    typedef struct {
        logic [127:0] data;
        logic [127:0] mask;
        logic         last;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic        pass;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [63:0] pc = '0;
    logic [31:0] instr = '0;
    logic        pc_valid = 1'b0;
    logic [4:0]  ctrl_addr = '0;
    logic [63:0] ctrl_wdata = '0;
    logic        ctrl_we = 1'b0;
    logic [15:0] tlast_interval = '0;
    logic [1:0]  state;
    logic [15:0] drop_count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cms_trace_engine_if #(.DATA_W(128)) m_axis ();

    cms_trace_engine dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr), .pc_valid(pc_valid),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_we(ctrl_we),
        .tlast_interval(tlast_interval), .M_AXIS(m_axis), .state(state), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    // Every transferred beat is compared against the oldest expected packet.
    always @(negedge clk) begin
        if (!rst && m_axis.tvalid && m_axis.tready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat actual=%h last=%b required=none", m_axis.tdata, m_axis.tlast);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((((m_axis.tdata ^ e.data) & e.mask) != '0) || (m_axis.tlast !== e.last)) begin
                    errors++;
                    $display("[TB] FAIL beat actual=%h last=%b required=%h last=%b (mask %h)",
                             m_axis.tdata, m_axis.tlast, e.data, e.last, e.mask);
                end
            end
        end
    end

    function automatic exp_t mkExp(input logic [31:0] ins, input logic [63:0] p,
                                   input logic [31:0] ts, input logic ts_chk, input logic last);
        exp_t e;
        e.data = {ins, ts, p};
        e.mask = ts_chk ? {128{1'b1}} : {32'hFFFF_FFFF, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        e.last = last;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] p, input logic [31:0] ins, input logic exp_beat,
                                 input logic exp_last);
        pc       = p;
        instr    = ins;
        pc_valid = 1'b1;
        if (exp_beat) sb.push_back(mkExp(ins, p, 32'h0, 1'b0, exp_last));
        step();
        pc_valid = 1'b0;
    endtask

    task automatic writeCtrl(input logic [4:0] a, input logic [63:0] d);
        ctrl_addr  = a;
        ctrl_wdata = d;
        ctrl_we    = 1'b1;
        step();
        ctrl_we    = 1'b0;
    endtask

    task automatic doReset();
        rst            = 1'b1;
        en             = 1'b0;
        pc_valid       = 1'b0;
        ctrl_we        = 1'b0;
        tlast_interval = '0;
        m_axis.tready  = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        checkOutput(name, sb.size(), 0);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{64'h0FFC, 1'b0};
        vecs[1] = '{64'h1000, 1'b1};
        vecs[2] = '{64'h10FF, 1'b1};
        vecs[3] = '{64'h1100, 1'b0};
        vecs[4] = '{64'h1080, 1'b1};
        vecs[5] = '{64'h0000, 1'b0};

        m_axis.tready = 1'b1;
        doReset();
        checkOutput("reset_tvalid", m_axis.tvalid, 0);
        checkOutput("reset_tlast", m_axis.tlast, 0);
        checkOutput("reset_tdata", m_axis.tdata, 0);
        checkOutput("reset_state", state, 0);
        checkOutput("reset_drop", drop_count, 0);

        // Free-running trace: latency of two cycles and unit deltas on back-to-back captures.
        en = 1'b1;
        step();
        checkOutput("t1_state_tracing", state, 2);
        for (int k = 0; k < 4; k++) begin
            pc       = 64'h100 + 64'(4 * k);
            instr    = 32'h0000_0013 + 32'(k);
            pc_valid = 1'b1;
            sb.push_back(mkExp(instr, pc, 32'd1, k != 0, 1'b0));
            @(negedge clk);
            checkOutput($sformatf("t1_tvalid_cycle%0d", k), m_axis.tvalid, (k >= 2) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        pc_valid = 1'b0;
        waitDrain("t1_drain", 50);
        en = 1'b0;
        step();
        checkOutput("t1_state_idle", state, 0);

        // Start/end triggers.
        doReset();
        writeCtrl(5'd0, 64'h3);
        writeCtrl(5'd1, 64'h200);
        writeCtrl(5'd2, 64'h240);
        en = 1'b1;
        step();
        checkOutput("t2_state_armed", state, 1);
        for (logic [63:0] p = 64'h1F0; p <= 64'h250; p += 64'h4) begin
            applyStimulus(p, p[31:0] ^ 32'hA5A5_0000, (p >= 64'h200) && (p <= 64'h240), p == 64'h240);
        end
        waitDrain("t2_drain", 50);
        checkOutput("t2_state_done", state, 3);

        // Range filter, table-driven.
        doReset();
        writeCtrl(5'd3, 64'h1000);
        writeCtrl(5'd4, 64'h10FF);
        writeCtrl(5'd0, 64'h4);
        en = 1'b1;
        step();
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].pc, 32'h0000_0033, vecs[i].pass, 1'b0);
        waitDrain("t3_drain", 50);

        // FIFO overflow with the sink stalled.
        doReset();
        m_axis.tready = 1'b0;
        en = 1'b1;
        step();
        for (int k = 0; k < 20; k++) applyStimulus(64'h4000 + 64'(4 * k), 32'h0000_0013, k < 16, 1'b0);
`ifdef CMS_OVERFLOW_MARKER_EN
        sb.push_back(mkExp(32'hFFFF_FFFF, 64'd4, 32'd0, 1'b1, 1'b0));
`endif
        repeat (3) step();
        checkOutput("t4_drop_count", drop_count, 4);
        checkOutput("t4_tvalid_stalled", m_axis.tvalid, 1);
        m_axis.tready = 1'b1;
        waitDrain("t4_drain", 80);
        checkOutput("t4_drop_hold", drop_count, 4);

        // Count-based tlast every third packet.
        doReset();
        tlast_interval = 16'd3;
        en = 1'b1;
        step();
        for (int k = 0; k < 7; k++) applyStimulus(64'h8000 + 64'(4 * k), 32'h0000_0013, 1'b1, (k == 2) || (k == 5));
        waitDrain("t5_drain", 50);

        // WFI stop after the 255th consecutive valid WFI.
        doReset();
        en = 1'b1;
        step();
        for (int k = 0; k < 254; k++) applyStimulus(64'h9000, WFI, 1'b1, 1'b0);
        checkOutput("t6_state_254", state, 2);
        applyStimulus(64'h9000, WFI, 1'b1, 1'b0);
        checkOutput("t6_state_255", state, 3);
        applyStimulus(64'h9000, WFI, 1'b0, 1'b0);
        waitDrain("t6_drain", 50);

        // Reset in the middle of a buffered burst.
        doReset();
        m_axis.tready = 1'b0;
        en = 1'b1;
        step();
        for (int k = 0; k < 6; k++) applyStimulus(64'hA000 + 64'(4 * k), 32'h0000_0013, 1'b0, 1'b0);
        repeat (2) step();
        checkOutput("t7_tvalid_before", m_axis.tvalid, 1);
        rst = 1'b1;
        step();
        checkOutput("t7_tvalid_rst", m_axis.tvalid, 0);
        checkOutput("t7_state_rst", state, 0);
        rst = 1'b0;
        en  = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) step();
        checkOutput("t7_fifo_empty", m_axis.tvalid, 0);
        checkOutput("final_scoreboard", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
